// File: rtl/aes_decrypt_if.sv
// aes_decrypt_if: request/result bundle for aes_decrypt
// Signals: start (level request), keyIn/data_in (128-bit key and ciphertext, byte 0 in bits 127:120),
// ready (idle with valid result), data_out (plaintext of the last completed operation).
// Modports: master drives requests and reads results; slave is the decryptor side.
interface aes_decrypt_if;
  logic         start;
  logic [127:0] keyIn;
  logic [127:0] data_in;
  logic         ready;
  logic [127:0] data_out;
  modport master (output start, keyIn, data_in, input ready, data_out);
  modport slave (input start, keyIn, data_in, output ready, data_out);
endinterface

// File: rtl/aes_decrypt.sv
// aes_decrypt: iterative AES-128 decryptor, forward key expansion then ten inverse rounds
// Ports: clk, rst_n (async active-low), bus (aes_decrypt_if.slave: start, keyIn, data_in -> ready, data_out).
// Option: define AES_DEC_KEYCACHE_EN to cache the last key and its K10, so a repeated key skips key expansion.
module aes_decrypt (
  input  logic         clk,
  input  logic         rst_n,
  aes_decrypt_if.slave bus
);
  typedef enum logic [1:0] {IDLE, KEYEXP, DEC} state_e;
  state_e       state_q, state_d;
  logic         start_1_q, start_2_q, flag;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] key_q, key_d, st_q, st_d;
  logic         ready_q, ready_d;
  logic [127:0] sb_o, ark, kf, kb;
  logic [31:0]  k0, k1, k2, k3, sub_in, rot, sub_o, t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xt(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r, s;
    r = 8'h01;
    s = x;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] v;
    v = ginv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  assign flag = start_1_q & ~start_2_q;
  assign bus.ready = ready_q;
  assign bus.data_out = st_q;

  // InvShiftRows folded into the byte selection feeding each inverse S-box
  for (genvar b = 0; b < 16; b++) begin : g_isb
    localparam int R = b % 4;
    localparam int C = b / 4;
    localparam int SRC = 4 * ((C - R + 4) % 4) + R;
    assign sb_o[127-8*b -: 8] = inv_sbox(st_q[127-8*SRC -: 8]);
  end

  // Forward and inverse expansion share the four S-boxes: forward substitutes the last word,
  // inverse substitutes the recovered last word of the previous round key
  assign {k0, k1, k2, k3} = key_q;
  assign sub_in = (state_q == DEC) ? (k3 ^ k2) : k3;
  assign rot = {sub_in[23:0], sub_in[31:24]};
  for (genvar b = 0; b < 4; b++) begin : g_ksb
    assign sub_o[31-8*b -: 8] = fwd_sbox(rot[31-8*b -: 8]);
  end
  assign t = sub_o ^ {rcon_q, 24'h0};
  assign kf = {k0 ^ t, k1 ^ k0 ^ t, k2 ^ k1 ^ k0 ^ t, k3 ^ k2 ^ k1 ^ k0 ^ t};
  assign kb = {k0 ^ t, k1 ^ k0, k2 ^ k1, k3 ^ k2};
  assign ark = sb_o ^ kb;

`ifdef AES_DEC_KEYCACHE_EN
  logic         cv_q, cv_d, hit;
  logic [127:0] ckey_q, ckey_d, ck10_q, ck10_d;
  assign hit = cv_q && (bus.keyIn == ckey_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv_q   <= 1'b0;
      ckey_q <= '0;
      ck10_q <= '0;
    end else begin
      cv_q   <= cv_d;
      ckey_q <= ckey_d;
      ck10_q <= ck10_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    key_d   = key_q;
    st_d    = st_q;
    ready_d = ready_q;
`ifdef AES_DEC_KEYCACHE_EN
    cv_d    = cv_q;
    ckey_d  = ckey_q;
    ck10_d  = ck10_q;
`endif
    case (state_q)
      IDLE: if (flag) begin
        st_d    = bus.data_in;
        key_d   = bus.keyIn;
        rcon_d  = 8'h01;
        rnd_d   = 4'd0;
        ready_d = 1'b0;
        state_d = KEYEXP;
`ifdef AES_DEC_KEYCACHE_EN
        // the key is remembered now and marked valid once its K10 is known
        if (hit) begin
          st_d    = bus.data_in ^ ck10_q;
          key_d   = ck10_q;
          rcon_d  = 8'h36;
          state_d = DEC;
        end else begin
          cv_d   = 1'b0;
          ckey_d = bus.keyIn;
        end
`endif
      end
      KEYEXP: begin
        key_d = kf;
        rnd_d = rnd_q + 4'd1;
        // the last forward rcon (0x36) is kept: it is the first one the inverse schedule needs
        if (rnd_q == 4'd9) begin
          st_d    = st_q ^ kf;
          rnd_d   = 4'd0;
          state_d = DEC;
`ifdef AES_DEC_KEYCACHE_EN
          cv_d   = 1'b1;
          ck10_d = kf;
`endif
        end else begin
          rcon_d = xt(rcon_q);
        end
      end
      DEC: begin
        key_d  = kb;
        st_d   = (rnd_q == 4'd9) ? ark : inv_mix(ark);
        rcon_d = (rcon_q == 8'h1b) ? 8'h80 : {1'b0, rcon_q[7:1]};
        rnd_d  = rnd_q + 4'd1;
        if (rnd_q == 4'd9) begin
          rnd_d   = 4'd0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start_1_q <= 1'b0;
      start_2_q <= 1'b0;
      rnd_q     <= 4'd0;
      rcon_q    <= 8'h00;
      key_q     <= '0;
      st_q      <= '0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      start_1_q <= bus.start;
      start_2_q <= start_1_q;
      rnd_q     <= rnd_d;
      rcon_q    <= rcon_d;
      key_q     <= key_d;
      st_q      <= st_d;
      ready_q   <= ready_d;
    end
  end
endmodule

// File: tb/tb_aes_decrypt.sv
// tb_aes_decrypt: directed and random checks of aes_decrypt against a table-driven AES reference
module tb_aes_decrypt;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int compared = 0;
  int mismatched = 0;
  logic [7:0] sb [256];
  logic [7:0] isb [256];
  logic [7:0] ex [256];
  int         lg [256];
  logic         ck_v = 1'b0;
  logic [127:0] ck_key = '0;
`ifdef AES_DEC_KEYCACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  aes_decrypt_if bus();
  aes_decrypt dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    return (a == 8'h00 || b == 8'h00) ? 8'h00 : ex[(lg[a] + lg[b]) % 255];
  endfunction

  task automatic build_tables();
    logic [7:0] e, v;
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = e;
      lg[e] = i;
      e = e ^ {e[6:0], 1'b0} ^ (e[7] ? 8'h1b : 8'h00);
    end
    for (int i = 0; i < 256; i++) begin
      v = (i == 0) ? 8'h00 : ex[(255 - lg[i]) % 255];
      sb[i] = v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    end
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic logic [127:0] ref_dec(input logic [127:0] key, input logic [127:0] ct);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] out;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) begin
      tmp = w[40 + b/4];
      s[b] = ct[127-8*b -: 8] ^ tmp[31-8*(b%4) -: 8];
    end
    for (int r = 9; r >= 0; r--) begin
      for (int b = 0; b < 16; b++) begin
        tmp = w[4*r + b/4];
        t[b] = isb[s[4*(((b/4) - (b%4) + 4) % 4) + b%4]] ^ tmp[31-8*(b%4) -: 8];
      end
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          s[4*c+j] = (r == 0) ? t[4*c+j] :
            gm(t[4*c+j], 8'h0e) ^ gm(t[4*c+(j+1)%4], 8'h0b) ^ gm(t[4*c+(j+2)%4], 8'h0d) ^ gm(t[4*c+(j+3)%4], 8'h09);
    end
    for (int b = 0; b < 16; b++) out[127-8*b -: 8] = s[b];
    return out;
  endfunction

  function automatic int exp_lat(input logic [127:0] key);
    return (CACHE && ck_v && ck_key == key) ? 12 : 22;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic done(input logic [127:0] key);
    ck_v = 1'b1;
    ck_key = key;
  endtask

  task automatic run_op(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] exp, input string tag);
    int lat, el;
    el = exp_lat(key);
    bus.keyIn = key;
    bus.data_in = ct;
    bus.start = 1'b1;
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      tick();
      if (n == 1) bus.start = 1'b0;
      if (n == 2) check({tag, " busy"}, 128'(bus.ready), 128'(0));
      if (n > 2 && bus.ready) lat = n;
    end
    check({tag, " latency"}, 128'(lat), 128'(el));
    check({tag, " data"}, bus.data_out, exp);
    done(key);
  endtask

  initial begin
    logic [127:0] k, c, e, hold;
    int lat, rises, falls, el;
    logic prev;
    build_tables();
    bus.start = 1'b0;
    bus.keyIn = '0;
    bus.data_in = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset ready", 128'(bus.ready), 128'(1));
    check("reset data_out", bus.data_out, '0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle ready", 128'(bus.ready), 128'(1));

    run_op(K1, C1, P1, "fips c1");
    run_op(K2, C2, P2, "fips b");

    // second start rise mid-operation and data/key changes after acceptance are ignored
    el = exp_lat(K1);
    bus.keyIn = K1;
    bus.data_in = C1;
    bus.start = 1'b1;
    rises = 0;
    lat = 0;
    prev = bus.ready;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 1) bus.start = 1'b0;
      if (n == 4) begin
        bus.data_in = {$urandom, $urandom, $urandom, $urandom};
        bus.keyIn = {$urandom, $urandom, $urandom, $urandom};
      end
      if (n == 5) bus.start = 1'b1;
      if (bus.ready && !prev) rises++;
      if (n > 2 && bus.ready && lat == 0) lat = n;
      prev = bus.ready;
    end
    check("ignored flag latency", 128'(lat), 128'(el));
    check("ignored flag data", bus.data_out, P1);
    check("ignored flag ready rises", 128'(rises), 128'(1));
    done(K1);
    bus.start = 1'b0;
    repeat (3) tick();

    // flag landing exactly on the completing edge is dropped, not queued
    k = {$urandom, $urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom, $urandom};
    e = ref_dec(k, c);
    el = exp_lat(k);
    bus.keyIn = k;
    bus.data_in = c;
    bus.start = 1'b1;
    falls = 0;
    prev = bus.ready;
    for (int n = 1; n <= el + 20; n++) begin
      tick();
      if (n == 1) bus.start = 1'b0;
      if (n == el - 2) bus.start = 1'b1;
      if (n == el) bus.start = 1'b0;
      if (!bus.ready && prev) falls++;
      prev = bus.ready;
    end
    check("flag at completion falls", 128'(falls), 128'(1));
    check("flag at completion ready", 128'(bus.ready), 128'(1));
    check("flag at completion data", bus.data_out, e);
    done(k);

    // asynchronous reset mid-decryption aborts the operation
    bus.keyIn = K2;
    bus.data_in = C2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (13) tick();
    check("mid-op busy", 128'(bus.ready), 128'(0));
    rst_n = 1'b0;
    ck_v = 1'b0;
    #1;
    check("async reset ready", 128'(bus.ready), 128'(1));
    check("async reset data_out", bus.data_out, '0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post reset idle ready", 128'(bus.ready), 128'(1));
    check("post reset idle data", bus.data_out, '0);
    run_op(K2, C2, P2, "post reset");

    // start held high for 50 cycles gives one operation
    k = {$urandom, $urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom, $urandom};
    e = ref_dec(k, c);
    bus.keyIn = k;
    bus.data_in = c;
    bus.start = 1'b1;
    rises = 0;
    falls = 0;
    prev = bus.ready;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (bus.ready && !prev) rises++;
      if (!bus.ready && prev) falls++;
      prev = bus.ready;
    end
    check("held start falls", 128'(falls), 128'(1));
    check("held start rises", 128'(rises), 128'(1));
    check("held start ready", 128'(bus.ready), 128'(1));
    check("held start data", bus.data_out, e);
    done(k);
    bus.start = 1'b0;
    repeat (3) tick();
    hold = bus.data_out;
    check("result holds", hold, e);

    for (int i = 0; i < 5; i++) begin
      k = (i == 3) ? ck_key : {$urandom, $urandom, $urandom, $urandom};
      c = {$urandom, $urandom, $urandom, $urandom};
      run_op(k, c, ref_dec(k, c), $sformatf("random %0d", i));
    end

    run_op(K1, C1, P1, "key first");
    run_op(K1, C1, P1, "key repeat");
    run_op(K2, C2, P2, "key change");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/aes_decrypt.md
AES_DECRYPT -- requirements
Module: aes_decrypt

Interface
REQ-001 Parameters: none; the block is fixed AES-128, 10 rounds.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  level request; one operation per detected rising edge.
REQ-005 keyIn  input  128  cipher key, FIPS-197 byte order (byte 0 = bits 127:120).
REQ-006 data_in  input  128  ciphertext block, same byte order.
REQ-007 ready  output  1  high when idle; data_out holds a valid result.
REQ-008 data_out  output  128  plaintext of the last completed operation.

Function
REQ-009 start SHALL pass through two flops, start_1 then start_2; flag = start_1 & ~start_2.
REQ-010 States SHALL be IDLE, KEYEXP and DEC, with a 4-bit round counter and an 8-bit rcon register.
REQ-011 In IDLE with flag=1 (edge E0), the block SHALL:
- latch data_in into the state register;
- latch keyIn into the key register;
- set rcon=0x01 and ready<=0;
- enter KEYEXP.
REQ-012 KEYEXP SHALL run forward key expansion, one round key per cycle, over E1..E10.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- At E10: key register = K10, state <= state ^ K10, enter DEC.
REQ-013 DEC SHALL run one inverse round per cycle over E11..E20, for rounds r=9..0.
- Round r: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ K_r).
- Round 0 omits InvMixColumns.
- K_r SHALL be derived from K_{r+1} by inverse key expansion in the same cycle: w[i-4] = w[i] ^ SubWord(RotWord(w[i-1])) ^ rcon for the first word of each key, w[i-4] = w[i] ^ w[i-1] otherwise; rcon steps backwards.
REQ-014 At E20 the block SHALL set ready<=1 and return to IDLE; the state register drives data_out directly.
REQ-015 Latency SHALL be 20 rising edges from the edge that samples flag=1 to ready=1; add 2 edges from the start rise.
REQ-016 flag while ready=0, including at E20, SHALL be ignored; no queuing.
REQ-017 start held high SHALL produce exactly one operation.
REQ-018 data_out and ready SHALL hold until the next accepted flag.
REQ-019 S-boxes SHALL be built from one shared GF(2^8) inversion function (polynomial 0x11B).
- Forward S-box = affine(inv(x)).
- Inverse S-box = inv(affine^-1(x)).
- 16 inverse S-box instances in the datapath and 4 forward instances in the key path; no 256-entry ROM tables.
REQ-020 Changes on data_in and keyIn after E0 SHALL NOT affect the result.

Reset
REQ-021 rst_n low SHALL asynchronously force:
- state = IDLE;
- ready = 1;
- data_out = 0;
- start_1, start_2, round counter, rcon and key register = 0.
REQ-022 Reset asserted mid-operation SHALL abort the operation with no output; after release, the first valid operation needs a fresh start edge.

Configuration
REQ-023 Macro AES_DEC_KEYCACHE_EN defined:
- Cache the key and K10 with a valid bit at E10 of each KEYEXP.
- On flag, if the valid bit is set and keyIn equals the cached key: state <= data_in ^ cached K10, key <= cached K10, go directly to DEC, and ready rises at E10.
- A key miss SHALL follow the full path and refresh the cache.
- Reset SHALL clear the valid bit.
REQ-024 Macro AES_DEC_KEYCACHE_EN undefined: no cache storage; every operation takes the 20-edge path of REQ-015.

Verification
REQ-025 key 000102030405060708090a0b0c0d0e0f, data_in 69c4e0d86a7b0430d8cdb78070b4c55a, start pulse -> data_out 00112233445566778899aabbccddeeff, ready high exactly 22 edges after the start rise.
REQ-026 key 2b7e151628aed2a6abf7158809cf4f3c, data_in 3925841d02dc09fbdc118597196a0b32 -> data_out 3243f6a8885a308d313198a2e0370734.
REQ-027 Second start edge at E5, plus data_in changed at E3 -> ignored; REQ-025 result unchanged; single ready rise.
REQ-028 rst_n low at E12 -> ready=1 and data_out=0 immediately (asynchronous); a new start then gives the correct result.
REQ-029 start held high 50 cycles -> one operation only, ready stays 1 after completion.
REQ-030 With AES_DEC_KEYCACHE_EN, REQ-025 repeated with the same key -> same plaintext, ready after 10 edges from flag; a different key -> 20 edges.
